// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional per-requester beat counters are enabled with FIFO_WR_ARB_STATS_EN.
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned STAT_W = 16;

  // Increment a round-robin pointer modulo n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set bit of req at or after ptr.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    j     = 32'd0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && req[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_WR_ARB_STATS_EN to build saturating per-requester accepted-beat counters.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DATA_W  = 8,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                        wclk,
  input  logic                        reset_w,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_push,
  output logic [DATA_W-1:0]           fifo_wdata,
  output logic                        busy,
  output logic [IDX_W-1:0]            owner,
  output logic [NUM_REQ*STAT_W-1:0]   stat_beats
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  logic             cand_found;
  logic [IDX_W-1:0] cand_idx;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (cand_found),
    .idx   (cand_idx)
  );

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      data_arr[i] = req_data[i*int'(DATA_W) +: DATA_W];
    end
  end

  // State register; a reset abandons any packet in flight.
  always_ff @(posedge wclk or posedge reset_w) begin
    if (reset_w) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // Next-state logic: lock on a multi-beat winner, advance pointer past a finished packet.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      IDLE: begin
        if (cand_found && !fifo_full) begin
          owner_d = cand_idx;
          if (req_last[cand_idx]) begin
            rr_ptr_d = IDX_W'(rr_next(32'(cand_idx), NUM_REQ));
          end else begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (fifo_push && req_last[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = IDX_W'(rr_next(32'(owner_q), NUM_REQ));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: grant goes straight to the FIFO push in the same cycle.
  always_comb begin
    req_ready  = '0;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    case (state_q)
      IDLE: begin
        if (cand_found && !fifo_full) begin
          req_ready[cand_idx] = 1'b1;
          fifo_push           = 1'b1;
          fifo_wdata          = data_arr[cand_idx];
        end
      end
      LOCKED: begin
        req_ready[owner_q] = !fifo_full;
        fifo_push          = req_valid[owner_q] && !fifo_full;
        fifo_wdata         = data_arr[owner_q];
      end
      default: ;
    endcase
  end

  assign busy  = (state_q == LOCKED);
  assign owner = owner_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];
  logic [STAT_W-1:0] stat_d [NUM_REQ];

  // Saturating accepted-beat counters.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      stat_d[i] = stat_q[i];
      if (req_valid[i] && req_ready[i] && (stat_q[i] != {STAT_W{1'b1}})) begin
        stat_d[i] = stat_q[i] + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge wclk or posedge reset_w) begin
    if (reset_w) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      stat_beats[i*int'(STAT_W) +: STAT_W] = stat_q[i];
    end
  end
`else
  assign stat_beats = '0;
`endif

endmodule
